fsqrt_checker: RTL and testbench

- Hardware result checker for the fsqrt unit: consumes (operand x, result y) pairs, squares y with an internal pipelined single-precision squarer and compares y*y against x within a ULP tolerance.
- Accumulates pass/fail/skip counts and captures the first failing pair, so FPU self-test runs on FPGA without a simulator.
- Sits on the output side of the fsqrt datapath, opposite the stimulus source.

---
 rtl/fsqrt_checker.sv | 141 ++++++++++++++
 tb/tb_fsqrt_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_checker.sv
// Self-test checker for the fsqrt unit: squares y in a 3-stage single-precision
// squarer, compares y*y against x within TOL_ULP and keeps pass/fail/skip stats.
module fsqrt_checker #(
  parameter int TOL_ULP = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             ff_valid,
  output logic [31:0]      ff_x,
  output logic [31:0]      ff_y,
  output logic             busy
);

  localparam int STAGES = 3;
  localparam logic [30:0] TOL31 = 31'(TOL_ULP);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        skip;
    logic        y_ok;
  } pair_t;

  function automatic logic is_norm(input logic [31:0] v);
    return !v[31] && (v[30:23] != 8'h00) && (v[30:23] != 8'hFF);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [STAGES:1]   vld_pipe;
  logic              accept;
  pair_t             s1, s2, s3, s1_d;
  logic [23:0]       mant_y;
  logic [47:0]       prod_d, prod2;
  logic signed [9:0] esum_d, esum2, esum3, esum3_d, e_n;
  logic [22:0]       man, mq3, mq3_d;
  logic              guard, sticky;
  logic [23:0]       rnd;
  logic [30:0]       res, diff;
  logic              in_range, ok, s4_pass, s4_fail, s4_skip;

  assign in_ready = rstn & ~clear;
  assign accept   = in_valid & in_ready;
  assign busy     = |vld_pipe;

  assign s1_d   = '{x: in_x, y: in_y, skip: ~is_norm(in_x), y_ok: is_norm(in_y)};
  assign mant_y = {1'b1, s1.y[22:0]};
  assign prod_d = 48'(mant_y) * 48'(mant_y);
  // 2*ey - 127 keeps the biased form of the squared exponent
  assign esum_d = $signed({1'b0, s1.y[30:23], 1'b0}) - 10'sd127;

  always_comb begin
    if (prod2[47]) begin
      man    = prod2[46:24];
      guard  = prod2[23];
      sticky = |prod2[22:0];
      e_n    = esum2 + 10'sd1;
    end else begin
      man    = prod2[45:23];
      guard  = prod2[22];
      sticky = |prod2[21:0];
      e_n    = esum2;
    end
    rnd     = {1'b0, man} + 24'(guard & (sticky | man[0]));
    mq3_d   = rnd[22:0];
    esum3_d = rnd[23] ? e_n + 10'sd1 : e_n;
  end

  always_comb begin
    res      = {esum3[7:0], mq3};
    diff     = (res >= s3.x[30:0]) ? res - s3.x[30:0] : s3.x[30:0] - res;
    in_range = (esum3 >= 10'sd1) && (esum3 <= 10'sd254);
    ok       = s3.y_ok & in_range & (diff <= TOL31);
    s4_skip  = vld_pipe[3] & s3.skip;
    s4_pass  = vld_pipe[3] & ~s3.skip & ok;
    s4_fail  = vld_pipe[3] & ~s3.skip & ~ok;
  end

  // Datapath payload only needs to be meaningful alongside its valid bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      prod2 <= '0;
      esum2 <= '0;
      esum3 <= '0;
      mq3   <= '0;
    end else begin
      s1    <= s1_d;
      s2    <= s1;
      s3    <= s2;
      prod2 <= prod_d;
      esum2 <= esum_d;
      esum3 <= esum3_d;
      mq3   <= mq3_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      ff_valid <= 1'b0;
      ff_x     <= '0;
      ff_y     <= '0;
    end else if (clear) begin
      vld_pipe <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      skip_cnt <= '0;
      ff_valid <= 1'b0;
      ff_x     <= '0;
      ff_y     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (s4_pass) pass_cnt <= sat_inc(pass_cnt);
      if (s4_fail) fail_cnt <= sat_inc(fail_cnt);
      if (s4_skip) skip_cnt <= sat_inc(skip_cnt);
      if (s4_fail && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_x     <= s3.x;
        ff_y     <= s3.y;
      end
    end
  end

endmodule

// File: tb/tb_fsqrt_checker.sv
// Bench for fsqrt_checker: directed cases plus random pairs scored by a
// double-precision reference of y*y rounded to single.
module tb_fsqrt_checker;
  localparam int TOL = 2;

  logic        clk = 1'b0;
  logic        rstn, clear, in_valid, in_valid_s;
  logic [31:0] in_x, in_y;
  logic        in_ready, ff_valid, busy;
  logic [31:0] pass_cnt, fail_cnt, skip_cnt, ff_x, ff_y;
  logic        in_ready_s, ff_valid_s, busy_s;
  logic [3:0]  pass_s, fail_s, skip_s;
  logic [31:0] ff_x_s, ff_y_s;

  int n_chk = 0;
  int n_err = 0;
  int e_pass, e_fail, e_skip;
  logic e_ffv;
  logic [31:0] e_ffx, e_ffy;

  always #5 clk = ~clk;

  fsqrt_checker #(.TOL_ULP(TOL), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .ff_valid(ff_valid), .ff_x(ff_x), .ff_y(ff_y), .busy(busy));

  fsqrt_checker #(.TOL_ULP(TOL), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_x(in_x), .in_y(in_y), .pass_cnt(pass_s), .fail_cnt(fail_s), .skip_cnt(skip_s),
    .ff_valid(ff_valid_s), .ff_x(ff_x_s), .ff_y(ff_y_s), .busy(busy_s));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // 0 = pass, 1 = fail, 2 = skip; y*y formed exactly in double, then rounded to single
  function automatic int ref_class(input logic [31:0] x, input logic [31:0] y);
    real yv, sq;
    logic [63:0] b;
    logic [23:0] kr;
    logic [30:0] r, d;
    logic up;
    int e;
    if (x[31] || x[30:23] == 8'h00 || x[30:23] == 8'hFF) return 2;
    if (y[31] || y[30:23] == 8'h00 || y[30:23] == 8'hFF) return 1;
    yv = $bitstoreal({1'b0, {3'b0, y[30:23]} + 11'd896, y[22:0], 29'b0});
    sq = yv * yv;
    b  = $realtobits(sq);
    e  = int'(b[62:52]) - 896;
    up = b[28] & ((|b[27:0]) | b[29]);
    kr = {1'b0, b[51:29]} + {23'b0, up};
    if (kr[23]) e++;
    if (e < 1 || e > 254) return 1;
    r = {e[7:0], kr[22:0]};
    d = (r >= x[30:0]) ? r - x[30:0] : x[30:0] - r;
    return (d <= 31'(TOL)) ? 0 : 1;
  endfunction

  task automatic model(input logic [31:0] x, input logic [31:0] y);
    int c;
    c = ref_class(x, y);
    if (c == 0) e_pass++;
    else if (c == 2) e_skip++;
    else begin
      e_fail++;
      if (!e_ffv) begin
        e_ffv = 1'b1;
        e_ffx = x;
        e_ffy = y;
      end
    end
  endtask

  task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
    int k;
    logic [7:0] ex;
    logic [22:0] mx;
    logic [63:0] sb;
    logic [31:0] yt;
    real s;
    k  = $urandom_range(0, 9);
    mx = 23'($urandom);
    if (k == 0) begin
      x = $urandom;
      y = $urandom;
    end else if (k == 1) begin
      case ($urandom_range(0, 3))
        0: x = {1'b1, 31'($urandom)};
        1: x = {1'b0, 8'h00, mx};
        2: x = {1'b0, 8'hFF, mx};
        default: x = 32'h0;
      endcase
      y = $urandom;
    end else begin
      ex = 8'($urandom_range(1, 254));
      x  = {1'b0, ex, mx};
      s  = $sqrt($bitstoreal({1'b0, {3'b0, ex} + 11'd896, mx, 29'b0}));
      sb = $realtobits(s);
      yt = {1'b0, 8'(sb[62:52] - 11'd896), sb[51:29]};
      y  = yt + 32'($urandom_range(0, 8)) - 32'd4;
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [31:0] px [3];
  logic [31:0] py [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry;
    logic v;
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0;
    in_x = '0; in_y = '0;
    tick(2);
    chk("rst_ready", in_ready, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_skip", skip_cnt, 0);
    chk("rst_ffv", ff_valid, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    #1 chk("ready_up", in_ready, 1);
    tick(1);

    // single passing pair, exact 3-edge latency
    send(32'h40800000, 32'h40000000);
    chk("t1_busy", busy, 1);
    tick(2);
    chk("t1_early", pass_cnt, 0);
    tick(1);
    chk("t1_pass", pass_cnt, 1);
    chk("t1_fail", fail_cnt, 0);
    chk("t1_ffv", ff_valid, 0);
    chk("t1_idle", busy, 0);

    // first-failure capture holds across a second failure
    send(32'h40800000, 32'h40000002);
    tick(3);
    chk("t2_fail", fail_cnt, 1);
    chk("t2_ffv", ff_valid, 1);
    chk("t2_ffx", ff_x, 32'h40800000);
    chk("t2_ffy", ff_y, 32'h40000002);
    send(32'h3F800000, 32'h7F800000);
    tick(3);
    chk("t2_fail2", fail_cnt, 2);
    chk("t2_ffx2", ff_x, 32'h40800000);
    chk("t2_ffy2", ff_y, 32'h40000002);
    chk("t2_pass", pass_cnt, 1);

    // clear then skipped domain
    do_clear();
    chk("clr_pass", pass_cnt, 0);
    chk("clr_fail", fail_cnt, 0);
    chk("clr_ffv", ff_valid, 0);
    send(32'hBF800000, 32'h3F800000);
    send(32'h7FC00000, 32'h3F800000);
    send(32'h00000000, 32'h00000000);
    tick(3);
    chk("t3_skip", skip_cnt, 3);
    chk("t3_pass", pass_cnt, 0);
    chk("t3_fail", fail_cnt, 0);

    // back-to-back acceptance
    do_clear();
    px[0] = 32'h40800000; py[0] = 32'h40000000;
    px[1] = 32'h41100000; py[1] = 32'h40400000;
    px[2] = 32'h3F800000; py[2] = 32'h3F800000;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        in_x = px[i]; in_y = py[i]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("t4_busy%0d", i), busy, (i < 5) ? 1 : 0);
      chk($sformatf("t4_pass%0d", i), pass_cnt, (i >= 3) ? 64'(i - 2) : 0);
    end

    // clear with pairs in flight and in_valid held
    do_clear();
    in_x = 32'h40800000; in_y = 32'h40000000; in_valid = 1'b1;
    tick(2);
    clear = 1'b1;
    #1 chk("t5_ready", in_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    chk("t5_pass0", pass_cnt, 0);
    chk("t5_busy0", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_busy1", busy, 1);
    tick(3);
    chk("t5_pass1", pass_cnt, 1);
    tick(2);
    chk("t5_pass_hold", pass_cnt, 1);

    // random pairs against the reference model
    do_clear();
    e_pass = 0; e_fail = 0; e_skip = 0; e_ffv = 1'b0; e_ffx = '0; e_ffy = '0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      gen_pair(rx, ry);
      in_x = rx; in_y = ry; in_valid = v;
      if (v) model(rx, ry);
      @(negedge clk);
    end
    in_valid = 1'b0;
    tick(4);
    chk("rnd_pass", pass_cnt, 64'(e_pass));
    chk("rnd_fail", fail_cnt, 64'(e_fail));
    chk("rnd_skip", skip_cnt, 64'(e_skip));
    chk("rnd_ffv", ff_valid, e_ffv);
    chk("rnd_ffx", ff_x, e_ffx);
    chk("rnd_ffy", ff_y, e_ffy);

    // 4-bit counters saturate instead of wrapping
    in_x = 32'h40800000; in_y = 32'h40000002;
    in_valid_s = 1'b1;
    tick(15);
    in_valid_s = 1'b0;
    tick(3);
    chk("sat_15", fail_s, 4'hF);
    in_valid_s = 1'b1;
    tick(2);
    in_valid_s = 1'b0;
    tick(4);
    chk("sat_17", fail_s, 4'hF);
    chk("sat_pass", pass_s, 0);
    chk("sat_skip", skip_s, 0);
    chk("sat_ffv", ff_valid_s, 1);
    chk("sat_ffy", ff_y_s, 32'h40000002);

    // asynchronous reset mid-stream
    in_x = 32'h40800000; in_y = 32'h40000000; in_valid = 1'b1; in_valid_s = 1'b1;
    tick(2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_pass", pass_cnt, 0);
    chk("arst_fail", fail_cnt, 0);
    chk("arst_skip", skip_cnt, 0);
    chk("arst_ffv", ff_valid, 0);
    chk("arst_ffx", ff_x, 0);
    chk("arst_ffy", ff_y, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_fail_s", fail_s, 0);
    chk("arst_busy_s", busy_s, 0);
    chk("arst_ready_s", in_ready_s, 0);
    chk("arst_ffxs", ff_x_s, 0);
    in_valid = 1'b0; in_valid_s = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick(4);
    chk("post_rst_pass", pass_cnt, 0);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
